tnet_cmd_ctrl: RTL

TNET_CMD_CTRL -- requirements
Module: tnet_cmd_ctrl

---
 rtl/tnet_pkg.sv | 48 ++++
 rtl/tnet_rr_arb2.sv | 28 ++
 rtl/tnet_cmd_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tnet_pkg.sv
// Shared types for the TNET command controller: FSM state codes, status
// bit-field layout and the opcode bit that marks a command with no response.
package tnet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_TX   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } tnet_state_e;

  localparam int OP_NORSP_BIT  = 4;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_TERR      = 4;
  localparam int STAT_OVF       = 5;
  localparam int STAT_LGNT      = 6;
  localparam int STAT_PEND      = 7;
  localparam int STAT_CMD_LSB   = 8;
  localparam int STAT_ERR_LSB   = 16;

  function automatic logic [31:0] pack_status(
    input tnet_state_e st,
    input logic        busy,
    input logic        terr,
    input logic        ovf,
    input logic        lgnt,
    input logic        pend,
    input logic [7:0]  cmd_cnt,
    input logic [7:0]  err_cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 3] = st;
    s[STAT_BUSY]           = busy;
    s[STAT_TERR]           = terr;
    s[STAT_OVF]            = ovf;
    s[STAT_LGNT]           = lgnt;
    s[STAT_PEND]           = pend;
    s[STAT_CMD_LSB +: 8]   = cmd_cnt;
    s[STAT_ERR_LSB +: 8]   = err_cnt;
    return s;
  endfunction

endpackage

// File: rtl/tnet_rr_arb2.sv
// Two-way round-robin arbiter (PS vs tProc); grant is combinational, the
// last-grant register only moves when the caller commits a grant with upd.
module tnet_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ps,
  input  logic req_tp,
  input  logic upd,
  output logic gnt_ps,
  output logic gnt_tp,
  output logic last_gnt
);

  // last_gnt=1 means tProc was served last, so PS wins the next tie
  always_comb begin
    gnt_ps = req_ps & (~req_tp | last_gnt);
    gnt_tp = req_tp & (~req_ps | ~last_gnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (upd && (gnt_ps || gnt_tp)) begin
      last_gnt <= gnt_tp;
    end
  end

endmodule

// File: rtl/tnet_cmd_ctrl.sv
// Arbitrates PS and tProc commands onto the network TX port, waits for the
// matching response or a timeout, and reports progress in TNET_STATUS.
module tnet_cmd_ctrl
  import tnet_pkg::*;
#(
  parameter int TOUT_CYC = 1024
) (
  input  logic        ps_aclk,
  input  logic        ps_aresetn,
  input  logic [31:0] TNET_CTRL,
  input  logic [15:0] TNET_ADDR,
  input  logic [15:0] TNET_LEN,
  input  logic [31:0] RAXI_DT1,
  input  logic        c_cmd_req_i,
  input  logic [4:0]  c_cmd_op_i,
  input  logic [15:0] c_cmd_addr_i,
  input  logic [31:0] c_cmd_dt_i,
  output logic        c_cmd_ack_o,
  output logic        tx_req_o,
  output logic [4:0]  tx_op_o,
  output logic [15:0] tx_addr_o,
  output logic [15:0] tx_len_o,
  output logic [31:0] tx_dt_o,
  input  logic        tx_ack_i,
  input  logic        rx_vld_i,
  input  logic [4:0]  rx_op_i,
  input  logic [31:0] rx_dt1_i,
  input  logic [31:0] rx_dt2_i,
  output logic [31:0] TNET_W_DT1,
  output logic [31:0] TNET_W_DT2,
  output logic [31:0] TNET_STATUS,
  output logic        busy_o
);

  localparam logic [15:0] TOUT_LAST = 16'(TOUT_CYC - 1);

  tnet_state_e state;
  logic        ctrl_q;
  logic        ps_pend;
  logic        ovf;
  logic        tout_err;
  logic [7:0]  cmd_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] tout_cnt;
  logic        stat_vld;
  logic        gnt_ps;
  logic        gnt_tp;
  logic        last_gnt;
  logic        ps_edge;
  logic        unused_ctrl;

  assign ps_edge     = TNET_CTRL[0] & ~ctrl_q;
  assign unused_ctrl = ^TNET_CTRL[31:6];

  tnet_rr_arb2 u_arb (
    .clk      (ps_aclk),
    .rst_n    (ps_aresetn),
    .req_ps   (ps_pend),
    .req_tp   (c_cmd_req_i),
    .upd      (state == ST_ARB),
    .gnt_ps   (gnt_ps),
    .gnt_tp   (gnt_tp),
    .last_gnt (last_gnt)
  );

  always_ff @(posedge ps_aclk) begin
    // edge detector tracks the PS bit even in reset so a held-high bit is not a request
    ctrl_q <= TNET_CTRL[0];
    if (!ps_aresetn) begin
      state       <= ST_IDLE;
      ps_pend     <= 1'b0;
      ovf         <= 1'b0;
      tout_err    <= 1'b0;
      cmd_cnt     <= '0;
      err_cnt     <= '0;
      tout_cnt    <= '0;
      stat_vld    <= 1'b0;
      busy_o      <= 1'b0;
      c_cmd_ack_o <= 1'b0;
      tx_req_o    <= 1'b0;
      tx_op_o     <= '0;
      tx_addr_o   <= '0;
      tx_len_o    <= '0;
      tx_dt_o     <= '0;
      TNET_W_DT1  <= '0;
      TNET_W_DT2  <= '0;
    end else begin
      stat_vld    <= 1'b1;
      c_cmd_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ps_pend || c_cmd_req_i) begin
            state  <= ST_ARB;
            busy_o <= 1'b1;
          end
        end
        ST_ARB: begin
          if (gnt_ps) begin
            tx_op_o   <= TNET_CTRL[5:1];
            tx_addr_o <= TNET_ADDR;
            tx_len_o  <= TNET_LEN;
            tx_dt_o   <= RAXI_DT1;
            ps_pend   <= 1'b0;
            ovf       <= 1'b0;
            tout_err  <= 1'b0;
            tx_req_o  <= 1'b1;
            state     <= ST_TX;
          end else if (gnt_tp) begin
            tx_op_o     <= c_cmd_op_i;
            tx_addr_o   <= c_cmd_addr_i;
            tx_len_o    <= '0;
            tx_dt_o     <= c_cmd_dt_i;
            c_cmd_ack_o <= 1'b1;
            tx_req_o    <= 1'b1;
            state       <= ST_TX;
          end else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        ST_TX: begin
          if (tx_ack_i) begin
            tx_req_o <= 1'b0;
            tout_cnt <= '0;
            state    <= tx_op_o[OP_NORSP_BIT] ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // a matching response beats a timeout landing in the same cycle
          if (rx_vld_i && (rx_op_i == tx_op_o)) begin
            TNET_W_DT1 <= rx_dt1_i;
            TNET_W_DT2 <= rx_dt2_i;
            state      <= ST_DONE;
          end else if (tout_cnt == TOUT_LAST) begin
            state <= ST_ERR;
          end else begin
            tout_cnt <= tout_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          cmd_cnt <= cmd_cnt + 8'd1;
          state   <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        ST_ERR: begin
          tout_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
      if (ps_edge) begin
        if (ps_pend) ovf <= 1'b1;
        else         ps_pend <= 1'b1;
      end
    end
  end

  // stat_vld masks last_gnt so the whole status word reads zero while in reset
  assign TNET_STATUS = pack_status(state, busy_o, tout_err, ovf, last_gnt & stat_vld,
                                   ps_pend, cmd_cnt, err_cnt);

endmodule
